pipe_ctrl_gen: RTL and testbench
================================

Name: pipe_ctrl_gen

Overview:
Parametrised pipeline control unit, the successor to the fixed 6-bit stall controller. It generalises stall generation to STAGES pipeline stages and adds a registered flush/exception-redirect state machine. It also provides a stall watchdog and a saturating stall-cycle performance counter. It sits beside the pipeline and drives the per-stage stall vector, flush pulse and redirect PC to the pc_reg and all inter-stage registers.

Parameters:
STAGES, 6, number of pipeline stages; bit 0 = pc, rising index = later stage.
ADDR_W, 32, PC/redirect address width.
HANDLER_ADDR, 32'h00000020, exception handler entry PC.
FLUSH_GAP, 2, cycles after a flush during which new flush requests are ignored (>=1).
STALL_LIMIT, 255, consecutive stall cycles that trip the watchdog (>=1).
CNT_W, 32, width of the stall-cycle counter.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
stallreq  in  STAGES  stallreq[k]=1: stage k requests a stall; bit 0 ignored
flush_req  in  1  exception/eret request, sampled on clk
flush_eret  in  1  qualifies flush_req: 1 = return to epc_in, 0 = go to HANDLER_ADDR
epc_in  in  ADDR_W  return PC, sampled with flush_req
stall  out  STAGES  stall[k]=1 freezes stage k
flush  out  1  one-cycle pipeline flush pulse
new_pc  out  ADDR_W  redirect target, valid while flush=1
flush_busy  out  1  high in FLUSH and RECOVER states
stall_timeout  out  1  sticky watchdog flag
stall_cycles  out  CNT_W  saturating count of cycles with any stall bit set

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; flush=0; new_pc=0; stall_timeout=0; stall_cycles=0; watchdog count=0; stall=0 regardless of stallreq.
- Stall generation (combinational from stallreq and state):
  - kmax = highest k>=1 with stallreq[k]=1.
  - stall[kmax:0] = all 1; higher bits = 0; no request gives stall=0.
  - With STAGES=6, a request on bit 2 yields 6'b000111 and on bit 3 yields 6'b001111.
  - In FLUSH state stall is forced to 0.
- Flush FSM with states IDLE, FLUSH, RECOVER:
  - IDLE -> FLUSH on a clk edge with flush_req=1. The same edge latches the target: epc_in if flush_eret=1, else HANDLER_ADDR.
  - FLUSH lasts exactly 1 cycle: flush=1, new_pc=latched target, stall=0. Next state is RECOVER.
  - RECOVER lasts FLUSH_GAP cycles, counted down from FLUSH_GAP-1 to 0, then returns to IDLE. Stalls operate normally in RECOVER.
  - flush_req is ignored in FLUSH and RECOVER; there is no queueing.
  - Latency from flush_req sampled to flush=1 is one cycle.
  - flush_req and stallreq in the same IDLE cycle: the stall is applied in that cycle and the flush follows next cycle, overriding any stall.
  - new_pc holds its last value outside FLUSH; consumers qualify it with flush.
- Watchdog:
  - The counter increments each cycle with |stall=1 and clears on any cycle with stall=0.
  - It saturates at STALL_LIMIT. On reaching STALL_LIMIT, stall_timeout is set on that edge.
  - stall_timeout is sticky and clears only on reset.
  - A flush cycle (stall=0) clears the counter.
- stall_cycles: +1 on each edge where |stall=1; holds at 2^CNT_W-1 with no wrap.
- Reset asserted mid-flush: immediate return to IDLE, flush=0, with no residual pulse after release.

Test Plan:
- Reset: hold rst=0 with stallreq=6'b111110 -> stall=0, flush=0, stall_cycles=0; release rst -> stall=6'b111111 in the same cycle.
- Priority encode, STAGES=6: stallreq=6'b000100 -> stall=6'b000111; stallreq=6'b001100 -> 6'b001111; stallreq=6'b000001 -> 6'b000000.
- Exception flush: pulse flush_req=1, flush_eret=0 for one cycle -> next cycle flush=1, new_pc=32'h20, flush_busy=1. Then RECOVER lasts 2 cycles, flush_busy drops and the FSM is back in IDLE.
- Eret plus ignored request: flush_req=1, flush_eret=1, epc_in=32'h0000_1234 -> flush=1 with new_pc=32'h1234. A second flush_req during RECOVER produces no further flush pulse.
- Simultaneous events: stallreq=6'b001000 and flush_req=1 in the same cycle -> stall=6'b001111 that cycle; next cycle stall=0 and flush=1.
- Watchdog and counter: STALL_LIMIT=4, CNT_W=3, hold stallreq[3]=1 -> stall_timeout rises after the 4th stalled edge, stall_cycles saturates at 7. Dropping the stall leaves stall_timeout=1 until rst.

Source files
------------

// File: rtl/pipe_ctrl_gen.sv
// pipe_ctrl_gen: per-stage stall generation, flush/redirect FSM, stall watchdog and stall-cycle counter
// Ports:
//   clk           system clock, all state on rising edge
//   rst           asynchronous active-low reset
//   stallreq      per-stage stall requests (bit 0 ignored)
//   flush_req     flush request, sampled on clk
//   flush_eret    1: redirect to epc_in, 0: redirect to HANDLER_ADDR
//   epc_in        return PC, sampled with flush_req
//   stall         per-stage freeze vector
//   flush         one-cycle flush pulse
//   new_pc        redirect target, valid while flush=1
//   flush_busy    high in FLUSH and RECOVER
//   stall_timeout sticky watchdog flag
//   stall_cycles  saturating count of stalled cycles
module pipe_ctrl_gen #(
    parameter int                 STAGES       = 6,
    parameter int                 ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]  HANDLER_ADDR = 32'h00000020,
    parameter int                 FLUSH_GAP    = 2,
    parameter int                 STALL_LIMIT  = 255,
    parameter int                 CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq,
    input  logic              flush_req,
    input  logic              flush_eret,
    input  logic [ADDR_W-1:0] epc_in,
    output logic [STAGES-1:0] stall,
    output logic              flush,
    output logic [ADDR_W-1:0] new_pc,
    output logic              flush_busy,
    output logic              stall_timeout,
    output logic [CNT_W-1:0]  stall_cycles
);
    localparam int GAP_W = $clog2(FLUSH_GAP + 1);
    localparam int WD_W  = $clog2(STALL_LIMIT + 1);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(FLUSH_GAP - 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(STALL_LIMIT);
    localparam logic [WD_W-1:0]  WD_TRIP  = WD_W'(STALL_LIMIT - 1);
    typedef enum logic [1:0] {IDLE, FLUSH, RECOVER} state_t;
    state_t            state, state_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_nxt;
    logic [WD_W-1:0]   wd_cnt;
    logic [STAGES-1:0] req, stall_mask;
    logic              any_req, any_stall;
    // Bit 0 (pc) never requests on its own, but is frozen by any later request.
    assign req = stallreq & ~STAGES'(1);
    // Thermometer fill: every stage at or below the latest requester stalls.
    always_comb begin
        any_req    = 1'b0;
        stall_mask = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            any_req       = any_req | req[k];
            stall_mask[k] = any_req;
        end
    end
    // Reset gates stall combinationally so the pipeline is never frozen during reset.
    assign stall      = (rst && state != FLUSH) ? stall_mask : '0;
    assign any_stall  = |stall;
    assign flush      = state == FLUSH;
    assign flush_busy = state != IDLE;
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        unique case (state)
            IDLE:    state_nxt = flush_req ? FLUSH : IDLE;
            FLUSH: begin
                state_nxt = RECOVER;
                gap_nxt   = GAP_INIT;
            end
            RECOVER: begin
                state_nxt = gap_cnt == '0 ? IDLE : RECOVER;
                gap_nxt   = gap_cnt == '0 ? gap_cnt : gap_cnt - 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            gap_cnt       <= '0;
            new_pc        <= '0;
            wd_cnt        <= '0;
            stall_timeout <= 1'b0;
            stall_cycles  <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
            if (state == IDLE && flush_req)
                new_pc <= flush_eret ? epc_in : HANDLER_ADDR;
            wd_cnt <= !any_stall ? '0 : (wd_cnt == WD_MAX ? wd_cnt : wd_cnt + 1'b1);
            if (any_stall && wd_cnt == WD_TRIP)
                stall_timeout <= 1'b1;
            if (any_stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// tb_pipe_ctrl_gen: directed table-driven bench for pipe_ctrl_gen (STALL_LIMIT=4, CNT_W=3)
module tb_pipe_ctrl_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stallreq;
    logic        flush_req, flush_eret;
    logic [31:0] epc_in;
    logic [5:0]  stall;
    logic        flush, flush_busy, stall_timeout;
    logic [31:0] new_pc;
    logic [2:0]  stall_cycles;
    int errors = 0;
    int checks = 0;

    pipe_ctrl_gen #(.STAGES(6), .ADDR_W(32), .HANDLER_ADDR(32'h20), .FLUSH_GAP(2),
                    .STALL_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req),
        .flush_eret(flush_eret), .epc_in(epc_in), .stall(stall), .flush(flush),
        .new_pc(new_pc), .flush_busy(flush_busy), .stall_timeout(stall_timeout),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {logic [5:0] req; logic [5:0] exp;} vec_t;
    typedef struct {logic s; int cnt; logic to;} wd_t;
    vec_t vecs[8];
    wd_t  wds[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{6'b000100, 6'b000111};
        vecs[1] = '{6'b001100, 6'b001111};
        vecs[2] = '{6'b000001, 6'b000000};
        vecs[3] = '{6'b000000, 6'b000000};
        vecs[4] = '{6'b100000, 6'b111111};
        vecs[5] = '{6'b000010, 6'b000011};
        vecs[6] = '{6'b010101, 6'b011111};
        vecs[7] = '{6'b111111, 6'b111111};
        wds[0]  = '{1'b1, 1, 1'b0};
        wds[1]  = '{1'b1, 2, 1'b0};
        wds[2]  = '{1'b1, 3, 1'b0};
        wds[3]  = '{1'b0, 3, 1'b0};
        wds[4]  = '{1'b1, 4, 1'b0};
        wds[5]  = '{1'b1, 5, 1'b0};
        wds[6]  = '{1'b1, 6, 1'b0};
        wds[7]  = '{1'b1, 7, 1'b1};
        wds[8]  = '{1'b1, 7, 1'b1};
        wds[9]  = '{1'b1, 7, 1'b1};
        wds[10] = '{1'b0, 7, 1'b1};
        wds[11] = '{1'b0, 7, 1'b1};

        rst = 1'b1; stallreq = 6'b111110; flush_req = 1'b0; flush_eret = 1'b0; epc_in = '0;
        #1 rst = 1'b0;
        #20;
        check("reset_stall", stall, 6'b000000);
        check("reset_flush", flush, 0);
        check("reset_busy", flush_busy, 0);
        check("reset_cycles", stall_cycles, 0);
        check("reset_timeout", stall_timeout, 0);
        check("reset_new_pc", new_pc, 0);
        @(negedge clk) rst = 1'b1;
        #1 check("release_stall", stall, 6'b111111);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk) stallreq = vecs[i].req;
            #1 check($sformatf("prio_%0d", i), stall, vecs[i].exp);
        end

        // exception flush, stall request present during FLUSH and RECOVER
        @(negedge clk) begin stallreq = 6'b000000; flush_req = 1'b1; flush_eret = 1'b0; epc_in = 32'hdead; end
        @(negedge clk) begin flush_req = 1'b0; stallreq = 6'b000100; end
        #1;
        check("exc_flush", flush, 1);
        check("exc_new_pc", new_pc, 32'h20);
        check("exc_busy", flush_busy, 1);
        check("exc_stall_forced", stall, 6'b000000);
        step();
        check("exc_rec1_flush", flush, 0);
        check("exc_rec1_busy", flush_busy, 1);
        check("exc_rec1_stall", stall, 6'b000111);
        step();
        check("exc_rec2_busy", flush_busy, 1);
        step();
        check("exc_idle_busy", flush_busy, 0);
        check("exc_idle_flush", flush, 0);

        // eret, then a request during RECOVER that must be ignored
        @(negedge clk) begin stallreq = 6'b000000; flush_req = 1'b1; flush_eret = 1'b1; epc_in = 32'h1234; end
        @(negedge clk) flush_req = 1'b0;
        #1;
        check("eret_flush", flush, 1);
        check("eret_new_pc", new_pc, 32'h1234);
        @(negedge clk) begin flush_req = 1'b1; flush_eret = 1'b0; end
        #1 check("ign_rec1_flush", flush, 0);
        step();
        check("ign_rec2_flush", flush, 0);
        check("ign_rec2_busy", flush_busy, 1);
        @(negedge clk) flush_req = 1'b0;
        #1;
        check("ign_idle_busy", flush_busy, 0);
        check("ign_idle_flush", flush, 0);
        step();
        check("ign_no_pulse", flush, 0);
        check("ign_new_pc_hold", new_pc, 32'h1234);

        // simultaneous stall and flush request
        @(negedge clk) begin stallreq = 6'b001000; flush_req = 1'b1; end
        #1;
        check("sim_stall", stall, 6'b001111);
        check("sim_flush_pre", flush, 0);
        @(negedge clk) flush_req = 1'b0;
        #1;
        check("sim_stall_flush", stall, 6'b000000);
        check("sim_flush", flush, 1);
        @(negedge clk) stallreq = 6'b000000;
        step();
        step();
        check("sim_back_idle", flush_busy, 0);

        // reset asserted in the middle of a flush
        @(negedge clk) begin flush_req = 1'b1; flush_eret = 1'b0; end
        @(negedge clk) flush_req = 1'b0;
        #1 check("rmf_flush_before", flush, 1);
        #1 rst = 1'b0;
        #1;
        check("rmf_flush", flush, 0);
        check("rmf_busy", flush_busy, 0);
        check("rmf_new_pc", new_pc, 0);
        check("rmf_cycles", stall_cycles, 0);
        check("rmf_timeout", stall_timeout, 0);
        @(negedge clk) rst = 1'b1;
        step();
        check("rmf_no_residual", flush, 0);
        check("rmf_busy_after", flush_busy, 0);

        // watchdog clear-on-gap, trip, counter saturation, stickiness
        for (int i = 0; i < 12; i++) begin
            stallreq = wds[i].s ? 6'b001000 : 6'b000000;
            step();
            check($sformatf("wd_cycles_%0d", i), stall_cycles, wds[i].cnt);
            check($sformatf("wd_timeout_%0d", i), stall_timeout, wds[i].to);
        end
        #1 rst = 1'b0;
        #1 check("wd_timeout_cleared", stall_timeout, 0);
        check("wd_cycles_cleared", stall_cycles, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
